// File: rtl/analyzer_async_fifo.sv
// Single-clock capture FIFO (2**DEPTH_WIDTH x DATA_WIDTH) for the logic-analyzer upload path.
// Define ANALYZER_FIFO_OUTPUT_REG_EN to add an output pipeline register (2-cycle read latency).
module analyzer_async_fifo #(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WIDTH      = 12,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  almost_empty
);
    localparam int               LW     = DEPTH_WIDTH + 1;
    localparam logic [LW-1:0]    AF_LVL = LW'(ALMOST_FULL_NUM);
    localparam logic [LW-1:0]    AE_LVL = LW'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0] mem [1<<DEPTH_WIDTH];
    logic [LW-1:0]         wptr, rptr, wptr_next, rptr_next;
    logic [LW-1:0]         level, level_next;
    logic                  wr_ok, rd_ok;
    logic                  full_next, empty_next;
    logic [DATA_WIDTH-1:0] ram_q;

    // Acceptance uses the registered flags, so a full+read or empty+write cycle
    // accepts only the side that can legally proceed.
    assign wr_ok = wr_en && !wr_full;
    assign rd_ok = rd_en && !rd_empty;

    always_comb begin
        wptr_next  = wptr;
        rptr_next  = rptr;
        level_next = level;
        if (wr_ok)
            wptr_next = wptr + 1'b1;
        if (rd_ok)
            rptr_next = rptr + 1'b1;
        if (wr_ok && !rd_ok)
            level_next = level + 1'b1;
        else if (rd_ok && !wr_ok)
            level_next = level - 1'b1;
    end

    // Equal low bits: pointer MSBs tell full (differ) from empty (match).
    assign empty_next = (wptr_next == rptr_next);
    assign full_next  = (wptr_next[DEPTH_WIDTH] != rptr_next[DEPTH_WIDTH]) &&
                        (wptr_next[DEPTH_WIDTH-1:0] == rptr_next[DEPTH_WIDTH-1:0]);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            wptr         <= wptr_next;
            rptr         <= rptr_next;
            level        <= level_next;
            wr_full      <= full_next;
            almost_full  <= (level_next >= AF_LVL);
            rd_empty     <= empty_next;
            almost_empty <= (level_next <= AE_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr[DEPTH_WIDTH-1:0]] <= wr_data;
    end

    // Holds its value when no read is accepted.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst)
            ram_q <= '0;
        else if (rd_ok)
            ram_q <= mem[rptr[DEPTH_WIDTH-1:0]];
    end

`ifdef ANALYZER_FIFO_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst)
            out_q <= '0;
        else
            out_q <= ram_q;
    end

    assign rd_data = out_q;
`else
    assign rd_data = ram_q;
`endif

endmodule

// File: tb/tb_analyzer_async_fifo.sv
// Self-checking bench for analyzer_async_fifo: queue-based reference model compared every cycle,
// plus directed fill/drain/simultaneous/reset scenarios and a randomized traffic phase.
module tb_analyzer_async_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;
    localparam int AFN   = 1020;
    localparam int AEN   = 4;
`ifdef ANALYZER_FIFO_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          tb_rst = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          wr_full, almost_full, rd_empty, almost_empty;
    logic [DW-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    analyzer_async_fifo dut (
        .clk(clk), .tb_rst(tb_rst), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(wr_full), .almost_full(almost_full), .rd_en(rd_en),
        .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, read data as a latency chain.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_q1 = '0;
    logic [DW-1:0] m_q2 = '0;
    logic [DW-1:0] m_out;
    assign m_out = (LAT == 2) ? m_q2 : m_q1;

    always @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            q.delete();
            m_q1 = '0;
            m_q2 = '0;
        end else begin
            bit wa, ra;
            wa = wr_en && (q.size() < DEPTH);
            ra = rd_en && (q.size() > 0);
            m_q2 = m_q1;
            if (ra) m_q1 = q.pop_front();
            if (wa) q.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rd_data",      rd_data,      m_out);
        chk("wr_full",      {31'b0, wr_full},      {31'b0, q.size() == DEPTH});
        chk("rd_empty",     {31'b0, rd_empty},     {31'b0, q.size() == 0});
        chk("almost_full",  {31'b0, almost_full},  {31'b0, q.size() >= AFN});
        chk("almost_empty", {31'b0, almost_empty}, {31'b0, q.size() <= AEN});
    end

    task automatic step(input logic we, input logic re, input logic [DW-1:0] d);
        wr_en   = we;
        rd_en   = re;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] held;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data",      rd_data, 32'h0);
        chk("rst_rd_empty",     {31'b0, rd_empty}, 32'd1);
        chk("rst_almost_empty", {31'b0, almost_empty}, 32'd1);
        chk("rst_wr_full",      {31'b0, wr_full}, 32'd0);
        chk("rst_almost_full",  {31'b0, almost_full}, 32'd0);
        tb_rst = 1'b0;
        step(0, 0, 0);

        // Fill with a decrementing pattern; the 4097th word must be dropped.
        for (int i = 0; i <= DEPTH; i++) begin
            step(1, 0, 32'hFFFF_FFFF - DW'(i));
            if (i == 1018) chk("af_before", {31'b0, almost_full}, 32'd0);
            if (i == 1019) chk("af_rise",   {31'b0, almost_full}, 32'd1);
            if (i == 4094) chk("full_before", {31'b0, wr_full}, 32'd0);
            if (i == 4095) chk("full_rise",   {31'b0, wr_full}, 32'd1);
        end
        chk("fill_level", DW'(q.size()), 32'd4096);
        chk("fill_tail",  q[DEPTH-1], 32'hFFFF_F000);

        // Drain 4097 reads; the last one is ignored.
        for (int i = 0; i <= DEPTH; i++) begin
            step(0, 1, 0);
            if (i == LAT - 1) chk("drain_first", rd_data, 32'hFFFF_FFFF);
            if (i == 4090) chk("ae_before", {31'b0, almost_empty}, 32'd0);
            if (i == 4091) chk("ae_rise",   {31'b0, almost_empty}, 32'd1);
            if (i == 4094) chk("empty_before", {31'b0, rd_empty}, 32'd0);
            if (i == 4095) chk("empty_rise",   {31'b0, rd_empty}, 32'd1);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        chk("drain_last_hold", rd_data, 32'hFFFF_F000);

        // Level 10, then 100 cycles of simultaneous write+read.
        for (int j = 0; j < 10; j++) step(1, 0, 32'h100 + DW'(j));
        for (int j = 0; j < 100; j++) begin
            step(1, 1, $urandom);
            if (j == 0) chk("simul_first", rd_data, (LAT == 1) ? 32'h100 : 32'hFFFF_F000);
        end
        chk("simul_level", DW'(q.size()), 32'd10);
        chk("simul_ae",    {31'b0, almost_empty}, 32'd0);
        chk("simul_empty", {31'b0, rd_empty}, 32'd0);
        for (int j = 0; j < 12; j++) step(0, 1, 0);
        step(0, 0, 0);
        chk("simul_empty_end", {31'b0, rd_empty}, 32'd1);

        // Read on empty with a write: only the write lands.
        held = m_out;
        step(1, 1, 32'hA5A5_A5A5);
        chk("ewr_not_empty", {31'b0, rd_empty}, 32'd0);
        step(0, 0, 0);
        chk("ewr_data_held", rd_data, held);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("ewr_word", rd_data, 32'hA5A5_A5A5);

        // Reset with 50 words stored.
        for (int j = 0; j < 50; j++) step(1, 0, $urandom);
        tb_rst = 1'b1;
        #2;
        chk("mrst_empty",    {31'b0, rd_empty}, 32'd1);
        chk("mrst_ae",       {31'b0, almost_empty}, 32'd1);
        chk("mrst_rd_data",  rd_data, 32'h0);
        step(0, 0, 0);
        tb_rst = 1'b0;
        step(1, 0, 32'h1234_5678);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("mrst_first_word", rd_data, 32'h1234_5678);

        // Random traffic with a write-heavy then read-heavy bias.
        for (int k = 0; k < 6000; k++) begin
            int wp;
            wp = (k < 3000) ? 70 : 30;
            step(($urandom_range(99) < wp), ($urandom_range(99) < (100 - wp)), $urandom);
        end
        step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
